// File: rtl/rv32i_pkg.sv
// +--------------------------------------------------------------------+
// | rv32i_pkg                                                          |
// | Shared constants and types for the RV32I register file.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

  localparam int RV_XLEN  = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

`default_nettype wire

// File: rtl/register_file_mp_if.sv
// +--------------------------------------------------------------------+
// | register_file_mp_if                                                |
// | Decode/writeback bus of the multi-port register file.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface register_file_mp_if #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ_PORTS = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                             write_enable;
  logic [ADDR_W-1:0]                write_reg;
  logic [XLEN-1:0]                  write_data;
  logic [NUM_READ_PORTS*ADDR_W-1:0] read_reg;
  logic [NUM_READ_PORTS*XLEN-1:0]   read_data;
  logic [NUM_READ_PORTS-1:0]        read_busy;
  logic                             reserve_en;
  logic [ADDR_W-1:0]                reserve_reg;
  logic                             init_busy;

  modport master (
    output write_enable, write_reg, write_data, read_reg, reserve_en, reserve_reg,
    input  read_data, read_busy, init_busy
  );

  modport slave (
    input  write_enable, write_reg, write_data, read_reg, reserve_en, reserve_reg,
    output read_data, read_busy, init_busy
  );
endinterface

`default_nettype wire

// File: rtl/register_file_mp_scoreboard.sv
// +--------------------------------------------------------------------+
// | rf_scoreboard                                                      |
// | Per-register busy bits for hazard detection; set beats clear.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_scoreboard
  import rv32i_pkg::*;
#(
  parameter int  NUM_REGS       = 32,
  parameter int  NUM_READ_PORTS = 2,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input  wire logic                             clk,
  input  wire logic                             rst,
  input  wire logic                             i_ready,
  input  wire logic                             i_clr_en,
  input  wire logic [ADDR_W-1:0]                i_clr_idx,
  input  wire logic                             i_set_en,
  input  wire logic [ADDR_W-1:0]                i_set_idx,
  input  wire logic [NUM_READ_PORTS*ADDR_W-1:0] i_rd_idx,
  output logic      [NUM_READ_PORTS-1:0]        o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // A newly issued producer supersedes the one retiring in the same cycle.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_ready) begin
      if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
      if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_busy = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      o_busy[p] = r_busy[i_rd_idx[p*ADDR_W +: ADDR_W]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// +--------------------------------------------------------------------+
// | register_file_mp                                                   |
// | N-read/1-write register file with hardwired x0, post-reset clear   |
// | sequencer and busy scoreboard. Optional write-first forwarding is  |
// | enabled by defining REGFILE_WRITE_BYPASS_EN.                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module register_file_mp
  import rv32i_pkg::*;
#(
  parameter int  XLEN           = RV_XLEN,
  parameter int  NUM_REGS       = 32,
  parameter int  NUM_READ_PORTS = 2,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input wire logic          pll_1_200MHz,
  input wire logic          reset,
  register_file_mp_if.slave bus
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] C_ZERO_IDX = ADDR_W'(REG_ZERO);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic              r_init_busy;
  logic [XLEN-1:0]   r_regs [NUM_REGS];

  logic                      w_ready;
  logic                      w_rd_en;
  logic                      w_wr;
  logic [NUM_READ_PORTS-1:0] w_sb_busy;

  assign w_ready = (r_state == RF_READY);
  assign w_rd_en = w_ready & ~reset;
  assign w_wr    = w_ready & bus.write_enable & (bus.write_reg != C_ZERO_IDX);

  always_ff @(posedge pll_1_200MHz) begin
    if (reset) begin
      r_state     <= RF_CLEAR;
      r_clr_cnt   <= '0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_init_busy <= (w_state_nxt == RF_CLEAR);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      RF_CLEAR: begin
        if (r_clr_cnt == C_LAST_IDX) w_state_nxt = RF_READY;
        else                         w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      end
      RF_READY: ;
      default:  w_state_nxt = RF_CLEAR;
    endcase
  end

  // Storage needs no reset of its own: the clear sequence zeroes it.
  always_ff @(posedge pll_1_200MHz) begin
    if (!reset) begin
      if (r_state == RF_CLEAR) r_regs[r_clr_cnt]     <= '0;
      else if (w_wr)           r_regs[bus.write_reg] <= bus.write_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_scoreboard (
    .clk       (pll_1_200MHz),
    .rst       (reset),
    .i_ready   (w_ready),
    .i_clr_en  (bus.write_enable),
    .i_clr_idx (bus.write_reg),
    .i_set_en  (bus.reserve_en),
    .i_set_idx (bus.reserve_reg),
    .i_rd_idx  (bus.read_reg),
    .o_busy    (w_sb_busy)
  );

  always_comb begin
    logic [ADDR_W-1:0] w_idx;
    bus.read_data = '0;
    bus.read_busy = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      w_idx = bus.read_reg[p*ADDR_W +: ADDR_W];
      if (w_rd_en) begin
        if (w_idx != C_ZERO_IDX) bus.read_data[p*XLEN +: XLEN] = r_regs[w_idx];
        bus.read_busy[p] = w_sb_busy[p];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr && (bus.write_reg == w_idx)) begin
          bus.read_data[p*XLEN +: XLEN] = bus.write_data;
          if (!(bus.reserve_en && (bus.reserve_reg == w_idx))) bus.read_busy[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.init_busy = r_init_busy | reset;

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// +--------------------------------------------------------------------+
// | tb_register_file_mp                                                |
// | Directed stimulus with a queue-based scoreboard for the regfile.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_register_file_mp;

    localparam int K_D0   = 0;
    localparam int K_D1   = 1;
    localparam int K_B0   = 2;
    localparam int K_B1   = 3;
    localparam int K_INIT = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    register_file_mp_if #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) bus ();

    register_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) dut (
        .pll_1_200MHz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_D0:    return bus.read_data[31:0];
            K_D1:    return bus.read_data[63:32];
            K_B0:    return {31'b0, bus.read_busy[0]};
            K_B1:    return {31'b0, bus.read_busy[1]};
            default: return {31'b0, bus.init_busy};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            a = actual(e.kind);
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s (cycle %0d): got %h, want %h", e.name, e.cyc, a, e.val);
            end
        end
    end

    task automatic chk(input int kind, input logic [31:0] v, input string n);
        q.push_back('{cyc, kind, v, n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.read_reg = {a1, a0};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.write_enable = 1'b0; bus.write_reg = '0; bus.write_data = '0;
        bus.read_reg = '0; bus.reserve_en = 1'b0; bus.reserve_reg = '0;
        rd(5'd3, 5'd9);
        tick();
        chk(K_INIT, 32'd1, "init_in_reset");
        chk(K_D0, 32'd0, "rd_in_reset");
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            if (i == 4) begin
                bus.write_enable = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'hAAAA5555;
                bus.reserve_en = 1'b1; bus.reserve_reg = 5'd9;
                chk(K_D0, 32'd0, "rd_during_clear");
            end
            if (i == 5) begin
                bus.write_enable = 1'b0; bus.reserve_en = 1'b0;
            end
            chk(K_INIT, 32'd1, "init_clear");
            tick();
        end
        chk(K_INIT, 32'd0, "init_ready");
        n_cmp++;
        if (bus.init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_ready_direct: got %b, want 0", bus.init_busy);
        end

        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(r));
            chk(K_D0, 32'd0, "sweep_p0");
            chk(K_D1, 32'd0, "sweep_p1");
            chk(K_B0, 32'd0, "sweep_busy0");
            chk(K_B1, 32'd0, "sweep_busy1");
            tick();
        end

        bus.write_enable = 1'b1; bus.write_reg = 5'd5; bus.write_data = 32'hFFFFFFFF;
        tick();
        bus.write_enable = 1'b0; bus.write_data = 'x;
        rd(5'd5, 5'd5);
        chk(K_D0, 32'hFFFFFFFF, "x5_p0");
        chk(K_D1, 32'hFFFFFFFF, "x5_p1");
        #1;
        n_cmp++;
        if (bus.read_data[31:0] !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL x5_p0_direct: got %h, want ffffffff", bus.read_data[31:0]);
        end
        tick();

        bus.write_enable = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'hDEADBEEF;
        tick();
        bus.write_enable = 1'b0;
        rd(5'd0, 5'd0);
        chk(K_D0, 32'd0, "x0_p0");
        chk(K_D1, 32'd0, "x0_p1");
        #1;
        n_cmp++;
        if (bus.read_data[31:0] !== 32'd0) begin
            n_err++;
            $display("FAIL x0_p0_direct: got %h, want 00000000", bus.read_data[31:0]);
        end
        tick();

        bus.write_enable = 1'b1; bus.write_reg = 5'd7; bus.write_data = 32'h12345678;
        rd(5'd7, 5'd5);
`ifdef REGFILE_WRITE_BYPASS_EN
        chk(K_D0, 32'h12345678, "x7_same_cycle");
`else
        chk(K_D0, 32'd0, "x7_same_cycle");
`endif
        tick();
        bus.write_enable = 1'b0;
        chk(K_D0, 32'h12345678, "x7_next_cycle");
        tick();

        bus.reserve_en = 1'b1; bus.reserve_reg = 5'd9;
        rd(5'd9, 5'd9);
        chk(K_B0, 32'd0, "rsv9_same_cycle");
        tick();
        bus.reserve_en = 1'b0;
        chk(K_B0, 32'd1, "rsv9_busy");
        chk(K_B1, 32'd1, "rsv9_busy_p1");
        #1;
        n_cmp++;
        if (bus.read_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rsv9_busy_direct: got %b, want 1", bus.read_busy[0]);
        end
        tick();

        bus.write_enable = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h00000099;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk(K_B0, 32'd0, "wr9_same_cycle");
`else
        chk(K_B0, 32'd1, "wr9_same_cycle");
`endif
        tick();
        bus.write_enable = 1'b0;
        chk(K_B0, 32'd0, "wr9_cleared");
        chk(K_D0, 32'h00000099, "wr9_data");
        tick();

        bus.reserve_en = 1'b1; bus.reserve_reg = 5'd9;
        tick();
        bus.write_enable = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h00001111;
        chk(K_B0, 32'd1, "both9_same_cycle");
        tick();
        bus.write_enable = 1'b0; bus.reserve_en = 1'b0;
        chk(K_B0, 32'd1, "both9_set_wins");
        chk(K_D1, 32'h00001111, "both9_data");
        tick();

        bus.reserve_en = 1'b1; bus.reserve_reg = 5'd0;
        rd(5'd9, 5'd0);
        tick();
        bus.reserve_en = 1'b0;
        chk(K_B1, 32'd0, "rsv0_noop");
        chk(K_B0, 32'd1, "x9_still_busy");
        tick();

        bus.write_enable = 1'b1; bus.write_reg = 5'd12; bus.write_data = 32'h00005555;
        tick();
        rd(5'd12, 5'd9);
        bus.write_enable = 1'b1; bus.write_reg = 5'd12; bus.write_data = 32'h0000CAFE;
        reset = 1'b1;
        chk(K_INIT, 32'd1, "rst_ready_init");
        chk(K_D0, 32'd0, "rst_ready_rd");
        chk(K_B1, 32'd0, "rst_ready_busy");
        tick();
        bus.write_enable = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk(K_INIT, 32'd1, "clear_pre_restart");
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                bus.write_enable = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'hAAAA5555;
            end
            if (i == 1) bus.write_enable = 1'b0;
            chk(K_INIT, 32'd1, "clear_restarted");
            tick();
        end
        chk(K_INIT, 32'd0, "ready_after_restart");
        n_cmp++;
        if (bus.init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_restart_direct: got %b, want 0", bus.init_busy);
        end
        rd(5'd3, 5'd12);
        chk(K_D0, 32'd0, "x3_dropped");
        chk(K_D1, 32'd0, "x12_cleared");
        #1;
        n_cmp++;
        if (bus.read_data[31:0] !== 32'd0) begin
            n_err++;
            $display("FAIL x3_dropped_direct: got %h, want 00000000", bus.read_data[31:0]);
        end
        tick();
        rd(5'd5, 5'd9);
        chk(K_D0, 32'd0, "x5_cleared");
        chk(K_B1, 32'd0, "x9_busy_reset");
        tick();
        tick();
        tick();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s (cycle %0d): got unchecked, want checked", e.name, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised successor to the RV32I integer register file. It adds:
- N combinational read ports and one synchronous write port.
- Hardwired-zero x0.
- A post-reset clear sequencer that zeroes every register.
- A per-register busy scoreboard for pipeline hazard detection.

It sits between decode (reads, reservations) and writeback (writes) in the core pipeline.

Parameters:
XLEN, 32, data width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_READ_PORTS, 2, number of independent read ports (>=1)
ADDR_W, $clog2(NUM_REGS), register index width (localparam, not overridable)

Ports:
pll_1_200MHz  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
write_enable  input  1  write request this cycle
write_reg  input  ADDR_W  write index
write_data  input  XLEN  write data
read_reg  input  NUM_READ_PORTS*ADDR_W  packed read indices; port p at [p*ADDR_W +: ADDR_W]
read_data  output  NUM_READ_PORTS*XLEN  packed read data; port p at [p*XLEN +: XLEN]
read_busy  output  NUM_READ_PORTS  1 = register addressed by port p has an outstanding reservation
reserve_en  input  1  mark a register busy (issued producer)
reserve_reg  input  ADDR_W  register to mark busy
init_busy  output  1  1 while the clear sequence runs; all requests are ignored

Behaviour:
- Clock is pll_1_200MHz; reset is synchronous, active-high, sampled on the rising edge.
- States: CLEAR, READY.
- While reset=1:
  - state<=CLEAR, clr_cnt<=0.
  - All busy bits <=0.
  - init_busy=1; read_data=0 and read_busy=0 on all ports.
- CLEAR (reset=0):
  - Each cycle, reg[clr_cnt]<=0 and clr_cnt++.
  - When clr_cnt==NUM_REGS-1, that register is zeroed and state<=READY.
  - CLEAR lasts exactly NUM_REGS cycles after reset deasserts.
  - write_enable and reserve_en are ignored; read_data=0; read_busy=0.
- Reset mid-clear restarts the sequence at clr_cnt=0.
- READY:
  - init_busy=0 (registered; low in the first READY cycle).
  - Write: if write_enable and write_reg!=0, reg[write_reg]<=write_data at the rising edge.
  - read_data[p] = reg[read_reg[p]], combinational. Index 0 always returns 0.
  - Without bypass, a write is visible to reads in the cycle after the edge.
- Scoreboard, per cycle in READY:
  - write_enable clears busy[write_reg].
  - reserve_en sets busy[reserve_reg].
  - Same index for both: set wins, since the new producer supersedes the retiring one.
  - busy[0] is always 0; reserve and write to x0 are no-ops.
- read_busy[p] = busy[read_reg[p]], combinational from registered state.
- Multiple read ports may address the same register; each returns identical data.
- Writes with write_enable=0 never modify state, regardless of write_data (may be X).
- No arithmetic beyond clr_cnt; clr_cnt is ADDR_W bits and never wraps, because the transition occurs at NUM_REGS-1.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: in READY, if write_enable=1, write_reg!=0 and write_reg==read_reg[p], then read_data[p]=write_data in the same cycle. read_busy[p] is forced to 0 in the same cycle unless reserve_en targets the same index. This is a write-first register file.
- Undefined: no forwarding; reads return the stored value and the write appears next cycle. read_busy is derived purely from registered busy bits.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN default constant.
  - REG_ZERO index constant (0).
  - rf_state_t enum {RF_CLEAR, RF_READY}.
- Sub-module rf_scoreboard holds the busy vector, set/clear priority and per-port lookup.
  - Parameters: NUM_REGS, NUM_READ_PORTS.
  - Inputs: clock, reset, READY gating.
- Storage array, clear FSM and read muxing stay in register_file_mp.

Test Plan:
- Reset 2 cycles then release -> init_busy=1 for exactly 32 cycles then 0; all 32 registers read 0 on both ports; read_busy=0.
- READY: write x5=0xFFFFFFFF, next cycle read_reg port0=5, port1=5 -> both read_data=0xFFFFFFFF. Write x0=0xDEADBEEF, then read x0 -> 0.
- Same cycle write x7=0x12345678 and read port0=7 -> with REGFILE_WRITE_BYPASS_EN returns 0x12345678; without it returns the old value 0, and 0x12345678 the following cycle.
- Scoreboard:
  - reserve x9 -> next cycle read_busy[0]=1 at read_reg=9.
  - write x9 -> busy cleared the following cycle.
  - Simultaneous reserve x9 and write x9 -> busy stays 1.
  - Reserve x0 -> busy stays 0.
- Reset asserted at clear cycle 10, then released -> init_busy stays high 32 further cycles. Write attempts during clear (x3=0xAAAA5555) are dropped; x3 reads 0 after READY.
- Write during READY with reset asserted the same edge -> write dropped, state CLEAR, register later reads 0.
